// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx among NREQ byte producers, each
// with a one-byte holding register, and drives the transmitter's write handshake.
module uart_tx_arb #(
  parameter int NREQ        = 4,
  parameter int GNT_W       = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_we,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_full,
  output logic [NREQ-1:0]   req_ovf,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_ready,
  output logic [GNT_W-1:0]  gnt_id,
  output logic              busy,
  output logic              ack_err
);

  localparam int                 CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GNT_W-1:0]  ptr_q;
  logic [NREQ-1:0]   full_q, full_d;
  logic [NREQ-1:0]   ovf_q, ovf_d;
  logic [NREQ-1:0]   load, grant_oh;
  logic [7:0]        hold_q [NREQ];
  logic [7:0]        tx_data_q;
  logic              tx_we_q, tx_we_d;
  logic [GNT_W-1:0]  gnt_q;
  logic              busy_q;
  logic              ack_q, ack_d;
  logic              grant;
  logic              pick_valid;
  logic [GNT_W-1:0]  pick_idx, cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign grant_oh[gi] = grant && (pick_idx == GNT_W'(gi));
      // A write to a full register still lands if that byte leaves on this edge.
      assign load[gi]     = req_we[gi] && (!full_q[gi] || grant_oh[gi]);
      assign ovf_d[gi]    = req_we[gi] && full_q[gi] && !grant_oh[gi];
      assign full_d[gi]   = load[gi] || (full_q[gi] && !grant_oh[gi]);
    end
  endgenerate

  // Scan downward so the last hit is the nearest index after the pointer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GNT_W'((int'(ptr_q) + k) % NREQ);
      if (full_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_we_d = 1'b0;
    ack_d   = 1'b0;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant   = 1'b1;
          tx_we_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= GNT_W'(NREQ - 1);
      full_q    <= '0;
      ovf_q     <= '0;
      tx_data_q <= 8'h00;
      tx_we_q   <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      tx_we_q <= tx_we_d;
      busy_q  <= (state_d != S_IDLE);
      ack_q   <= ack_d;
      if (grant) begin
        tx_data_q <= hold_q[pick_idx];
        gnt_q     <= pick_idx;
        ptr_q     <= pick_idx;
      end
    end
  end

  // Byte storage needs no reset: req_full alone says whether it is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (load[i]) hold_q[i] <= req_data[8*i +: 8];
    end
  end

  assign req_full = full_q;
  assign req_ovf  = ovf_q;
  assign tx_data  = tx_data_q;
  assign tx_we    = tx_we_q;
  assign gnt_id   = gnt_q;
  assign busy     = busy_q;
  assign ack_err  = ack_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus random traffic,
// all compared each cycle against a queue-based reference model.
module tb_uart_tx_arb;

  localparam int NREQ        = 4;
  localparam int GNT_W       = 2;
  localparam int ACK_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_we = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_full, req_ovf;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              tx_ready = 1'b1;
  logic [GNT_W-1:0]  gnt_id;
  logic              busy, ack_err;

  uart_tx_arb #(.NREQ(NREQ), .GNT_W(GNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_we(req_we), .req_data(req_data),
    .req_full(req_full), .req_ovf(req_ovf), .tx_data(tx_data), .tx_we(tx_we),
    .tx_ready(tx_ready), .gnt_id(gnt_id), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each holding register is a queue of depth one, and a
  // transfer is a phase number with a timeout count while awaiting the ack.
  logic [7:0]       mq [NREQ][$];
  int               m_ptr = NREQ - 1, m_phase = 0, m_cnt = 0, m_grants = 0;
  logic [NREQ-1:0]  e_full = '0, e_ovf = '0;
  logic [7:0]       e_data = 8'h00;
  logic [GNT_W-1:0] e_gnt = '0;
  logic             e_we = 1'b0, e_busy = 1'b0, e_ack = 1'b0;

  task automatic model_step();
    int g;
    g     = -1;
    e_ovf = '0;
    e_we  = 1'b0;
    e_ack = 1'b0;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_phase = 0; m_ptr = NREQ - 1; m_cnt = 0;
      e_data  = 8'h00; e_gnt = '0;
    end else begin
      case (m_phase)
        0: begin
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (g < 0 && mq[c].size() > 0) g = c;
          end
          if (g >= 0) begin
            e_data = mq[g].pop_front();
            e_gnt  = GNT_W'(g);
            m_ptr  = g;
            m_phase = 1;
            e_we   = 1'b1;
            m_grants++;
          end
        end
        1: begin m_phase = 2; m_cnt = 0; end
        2: begin
          if (!tx_ready) m_phase = 3;
          else if (m_cnt == ACK_TIMEOUT - 1) begin e_ack = 1'b1; m_phase = 0; end
          else m_cnt++;
        end
        default: if (tx_ready) m_phase = 0;
      endcase
      for (int i = 0; i < NREQ; i++) begin
        if (req_we[i]) begin
          if (mq[i].size() == 0) mq[i].push_back(req_data[8*i +: 8]);
          else e_ovf[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) e_full[i] = (mq[i].size() > 0);
    e_busy = (m_phase != 0);
  endtask

  always @(posedge clk) model_step();

  // Monitor: per-cycle comparison and a log of transmitted bytes/events.
  bit   chk_en = 1'b0;
  int   cyc = 0;
  int   sent_q[$], we_cyc[$], ack_cyc[$];
  int   ovf1_cnt = 0, ovf_any_cnt = 0, we_double = 0, rise_cyc = -1, bfall_cyc = -1;
  logic p_we = 1'b0, p_rdy = 1'b1, p_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("req_full", 32'(req_full), 32'(e_full));
      check("req_ovf",  32'(req_ovf),  32'(e_ovf));
      check("tx_we",    32'(tx_we),    32'(e_we));
      check("tx_data",  32'(tx_data),  32'(e_data));
      check("gnt_id",   32'(gnt_id),   32'(e_gnt));
      check("busy",     32'(busy),     32'(e_busy));
      check("ack_err",  32'(ack_err),  32'(e_ack));
    end
    if (tx_we === 1'b1) begin
      sent_q.push_back(int'(gnt_id) * 256 + int'(tx_data));
      we_cyc.push_back(cyc);
      $display("tx cyc=%0d gnt=%0d data=%02h", cyc, gnt_id, tx_data);
      if (p_we) we_double++;
    end
    if (ack_err === 1'b1) ack_cyc.push_back(cyc);
    if (req_ovf[1] === 1'b1) ovf1_cnt++;
    if (req_ovf !== '0 && !$isunknown(req_ovf)) ovf_any_cnt++;
    if (tx_ready && !p_rdy) rise_cyc = cyc;
    if (busy === 1'b0 && p_busy) bfall_cyc = cyc;
    p_we = (tx_we === 1'b1); p_rdy = tx_ready; p_busy = (busy === 1'b1);
  end

  // Transmitter stand-in: ready drops rd cycles after tx_we falls, rises rl later.
  int r_drop = -1, r_rise = -1, rd_fix = -1, rl_fix = -1;
  bit r_prev_we = 1'b0, hold_mode = 1'b0, rand_lose = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #2;
      if (hold_mode) tx_ready = 1'b1;
      else begin
        if (r_prev_we && tx_we === 1'b0 && !(rand_lose && $urandom_range(0, 7) == 0))
          r_drop = (rd_fix >= 0) ? rd_fix : int'($urandom_range(0, 4));
        if (r_rise > 0) begin
          r_rise--;
          if (r_rise == 0) begin tx_ready = 1'b1; r_rise = -1; end
        end
        if (r_drop == 0) begin
          tx_ready = 1'b0;
          r_drop   = -1;
          r_rise   = (rl_fix >= 0) ? rl_fix : int'($urandom_range(1, 12));
        end else if (r_drop > 0) r_drop--;
      end
      r_prev_we = (tx_we === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic logic [8*NREQ-1:0] put(input int i, input logic [7:0] b);
    logic [8*NREQ-1:0] v;
    v = '0;
    v[8*i +: 8] = b;
    return v;
  endfunction

  function automatic int sent_at(input int i);
    return (i < sent_q.size()) ? sent_q[i] : -1;
  endfunction

  task automatic drive_cycle(input logic [NREQ-1:0] we, input logic [8*NREQ-1:0] d);
    req_we = we; req_data = d;
    tick();
    req_we = '0;
  endtask

  task automatic clear_logs();
    sent_q.delete(); we_cyc.delete(); ack_cyc.delete();
    ovf1_cnt = 0; ovf_any_cnt = 0; we_double = 0; rise_cyc = -1; bfall_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_we = '0; tx_ready = 1'b1; hold_mode = 1'b0;
    r_drop = -1; r_rise = -1; r_prev_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_grants = 0;
    clear_logs();
  endtask

  task automatic wait_sent(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin tick(); k++; end
    check(tag, 32'(sent_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (!(busy === 1'b0 && req_full === '0 && tx_ready) && k < budget) begin tick(); k++; end
    check(tag, 32'(busy === 1'b0 && req_full === '0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_full", 32'(req_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);

    // Single write with a 3-cycle ready drop and 10-cycle busy frame.
    rd_fix = 3; rl_fix = 10;
    drive_cycle(4'b0100, put(2, 8'hA5));
    wait_sent(1, 20, "t1_wait");
    check("t1_data", 32'(sent_at(0)), 32'h2A5);
    check("t1_full2_clear", 32'(req_full[2]), 32'd0);
    tick();
    check("t1_we_one_cycle", 32'(tx_we), 32'd0);
    wait_idle(100, "t1_idle");
    check("t1_busy_fall", 32'(bfall_cyc - rise_cyc), 32'd1);
    check("t1_we_double", 32'(we_double), 32'd0);

    // Round robin with requester 0 refilled right after its grant.
    do_reset(); rd_fix = -1; rl_fix = -1;
    drive_cycle(4'hF, {8'h13, 8'h12, 8'h11, 8'h10});
    wait_sent(1, 20, "t2_first");
    drive_cycle(4'b0001, put(0, 8'h20));
    wait_sent(5, 400, "t2_wait");
    check("t2_b0", 32'(sent_at(0)), 32'h010);
    check("t2_b1", 32'(sent_at(1)), 32'h111);
    check("t2_b2", 32'(sent_at(2)), 32'h212);
    check("t2_b3", 32'(sent_at(3)), 32'h313);
    check("t2_b4", 32'(sent_at(4)), 32'h020);
    wait_idle(200, "t2_idle");

    // Overflow on requester 1 while the transmitter is busy.
    do_reset(); rd_fix = 0; rl_fix = 30;
    drive_cycle(4'b0001, put(0, 8'h40));
    begin
      int k;
      k = 0;
      while (tx_ready && k < 50) begin tick(); k++; end
      check("t3_ready_low", 32'(tx_ready), 32'd0);
    end
    drive_cycle(4'b0010, put(1, 8'h55));
    drive_cycle(4'b0010, put(1, 8'h66));
    wait_sent(2, 200, "t3_wait");
    check("t3_ovf_pulses", 32'(ovf1_cnt), 32'd1);
    check("t3_byte", 32'(sent_at(1)), 32'h155);
    wait_idle(200, "t3_idle");

    // Refill of requester 3 on its own grant edge.
    do_reset(); rd_fix = -1; rl_fix = -1;
    drive_cycle(4'b1000, put(3, 8'h01));
    drive_cycle(4'b1000, put(3, 8'h02));
    check("t4_full3", 32'(req_full[3]), 32'd1);
    check("t4_we", 32'(tx_we), 32'd1);
    wait_sent(2, 200, "t4_wait");
    check("t4_b0", 32'(sent_at(0)), 32'h301);
    check("t4_b1", 32'(sent_at(1)), 32'h302);
    check("t4_no_ovf", 32'(ovf_any_cnt), 32'd0);
    wait_idle(200, "t4_idle");

    // Timeout: ready never falls.
    do_reset(); hold_mode = 1'b1;
    drive_cycle(4'b0011, put(0, 8'hC1) | put(1, 8'hC2));
    begin
      int k;
      k = 0;
      while (ack_cyc.size() < 2 && k < 400) begin tick(); k++; end
      check("t5_acks", 32'(ack_cyc.size()), 32'd2);
    end
    check("t5_delay", 32'(ack_cyc.size() > 0 ? ack_cyc[0] - (we_cyc[0] + 1) : -1), 32'(ACK_TIMEOUT));
    check("t5_b0", 32'(sent_at(0)), 32'h0C1);
    check("t5_b1", 32'(sent_at(1)), 32'h1C2);
    hold_mode = 1'b0;
    wait_idle(50, "t5_idle");

    // Reset during WAIT_DONE with two requesters full.
    do_reset(); rd_fix = 0; rl_fix = 40;
    drive_cycle(4'b0001, put(0, 8'h31));
    begin
      int k;
      k = 0;
      while (tx_ready && k < 50) begin tick(); k++; end
    end
    drive_cycle(4'b0110, put(1, 8'hA1) | put(2, 8'hA2));
    tick();
    check("t6_pre_full", 32'(req_full), 32'h6);
    check("t6_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_full", 32'(req_full), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_data", 32'(tx_data), 32'd0);
    check("t6_we", 32'(tx_we), 32'd0);
    clear_logs();
    repeat (30) tick();
    check("t6_quiet", 32'(sent_q.size()), 32'd0);
    drive_cycle(4'b0100, put(2, 8'h77));
    wait_sent(1, 50, "t6_wait");
    check("t6_fresh", 32'(sent_at(0)), 32'h277);
    wait_idle(300, "t6_idle");

    // Random traffic, occasional lost acks.
    do_reset(); rd_fix = -1; rl_fix = -1; rand_lose = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic [NREQ-1:0] w;
      w = '0;
      for (int i = 0; i < NREQ; i++) begin
        w[i] = ($urandom_range(0, 7) == 0);
        req_data[8*i +: 8] = 8'($urandom);
      end
      req_we = w;
      tick();
    end
    req_we = '0;
    wait_idle(3000, "rand_idle");
    check("rand_grants", 32'(sent_q.size()), 32'(m_grants));
    rand_lose = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
